// File: rtl/lut_sweep_reader.sv
// Sweeps every input code of a neuron LUT, samples its response and packs the
// resulting truth table LSB-first into a valid/ready word stream.
module lut_sweep_reader #(
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 1,
  parameter int WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [IN_BITS-1:0]   lut_addr,
  input  logic [OUT_BITS-1:0]  lut_data,
  output logic [WORD_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  localparam int EPW    = WORD_BITS / OUT_BITS;
  localparam int NWORDS = ((1 << IN_BITS) * OUT_BITS) / WORD_BITS;
  localparam int SL_W   = (EPW > 1) ? $clog2(EPW) : 1;
  localparam int WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEND} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IN_BITS-1:0]   r_addr;
  logic [WORD_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_done;
  logic [SL_W-1:0]      r_slot;
  logic [WC_W-1:0]      r_wcnt;

  logic w_slot_end;
  logic w_final;
  logic w_hs;

  assign w_slot_end = (r_slot == SL_W'(EPW - 1));
  assign w_final    = (r_wcnt == WC_W'(NWORDS - 1));
  assign w_hs       = r_valid & m_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_FILL;
      S_FILL: if (w_slot_end) w_next = S_SEND;
      S_SEND: if (w_hs) w_next = w_final ? S_IDLE : S_FILL;
      default: w_next = S_IDLE;
    endcase
  end

  // Reset also clears the data word so a mid-sweep reset leaves no stale state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_slot  <= '0;
      r_wcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= '0;
            r_slot <= '0;
          end
        end
        S_FILL: begin
          r_data[r_slot*OUT_BITS +: OUT_BITS] <= lut_data;
          r_addr <= r_addr + IN_BITS'(1);
          if (w_slot_end) begin
            r_slot  <= '0;
            r_valid <= 1'b1;
            r_last  <= w_final;
          end else begin
            r_slot <= r_slot + SL_W'(1);
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (w_final) begin
              r_wcnt <= '0;
              r_done <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + WC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign lut_addr = r_addr;
  assign m_data   = r_data;
  assign m_valid  = r_valid;
  assign m_last   = r_last;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_lut_sweep_reader.sv
// Directed bench for lut_sweep_reader: parity/MSB tables, backpressure,
// start-while-busy, mid-sweep reset and a 2-bit-output instance.
module tb_lut_sweep_reader;

  localparam int NW = 32;

  logic       clk = 1'b0;
  logic       rst, start, m_ready;
  logic [7:0] lut_addr, m_data;
  logic       lut_data, m_valid, m_last, busy, done;
  int         mode;

  logic       start2, ready2;
  logic [7:0] addr2, mdata2;
  logic [1:0] data2;
  logic       valid2, last2, busy2, done2;

  int tests = 0;
  int fails = 0;

  int nwords, ndone, done_cyc, data_err, last_err, stable_err, addr_err;
  int busy_err, stall_seen, stall_addr_err;
  logic [7:0] w0, w1;

  assign lut_data = (mode == 1) ? lut_addr[7] : ^lut_addr;
  assign data2    = addr2[1:0];

  lut_sweep_reader #(.IN_BITS(8), .OUT_BITS(1), .WORD_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .lut_addr(lut_addr), .lut_data(lut_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  lut_sweep_reader #(.IN_BITS(8), .OUT_BITS(2), .WORD_BITS(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .lut_addr(addr2), .lut_data(data2),
    .m_data(mdata2), .m_valid(valid2), .m_ready(ready2), .m_last(last2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int k);
    logic [4:0] kk;
    kk = 5'(k);
    if (mode == 1) return (k >= 16) ? 8'hFF : 8'h00;
    return (^kk) ? 8'h69 : 8'h96;
  endfunction

  task automatic sweep(input int stall_word, input int stall_len, input bit rnd,
                       input bit extra, input bit hold_end);
    int         cyc, stall_cnt;
    logic [7:0] exp_addr, held;
    logic       held_last;
    bit         stalled, hold_now;
    nwords = 0; ndone = 0; done_cyc = -1; data_err = 0; last_err = 0;
    stable_err = 0; addr_err = 0; busy_err = 0; stall_seen = 0; stall_addr_err = 0;
    stall_cnt = 0; stalled = 0; hold_now = 0; exp_addr = 8'd0; held = 8'd0; held_last = 1'b0;
    start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc < 3000) begin
      if (extra && (cyc == 5 || cyc == 100)) start = 1'b1;
      else if (!hold_now) start = 1'b0;
      if (m_valid && nwords == stall_word && stall_cnt < stall_len) begin
        m_ready = 1'b0; stall_cnt++; stall_seen++;
        if (lut_addr !== 8'd32) stall_addr_err++;
      end else if (rnd && nwords > stall_word) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
      if (stalled && (m_data !== held || m_last !== held_last)) stable_err++;
      if (busy && !m_valid) begin
        if (lut_addr !== exp_addr) addr_err++;
        exp_addr = exp_addr + 8'd1;
      end else if (m_valid && lut_addr !== exp_addr) addr_err++;
      if (m_valid && m_ready) begin
        if (m_data !== model(nwords)) data_err++;
        if (m_last !== (nwords == NW - 1)) last_err++;
        if (nwords == 0) w0 = m_data;
        if (nwords == 1) w1 = m_data;
        if (hold_end && m_last) begin start = 1'b1; hold_now = 1; end
        nwords++;
        stalled = 0;
      end else begin
        stalled = m_valid; held = m_data; held_last = m_last;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!hold_end && done_cyc >= 0 && cyc > done_cyc && busy) busy_err++;
      if (hold_end && done) break;
      if (!hold_end && done_cyc >= 0 && cyc > done_cyc + 3) break;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) check("sweep_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    int n, err, lerr, cyc;
    bit dn;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; mode = 0; start2 = 1'b0; ready2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(lut_addr), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Parity table, no backpressure
    mode = 0;
    sweep(-1, 0, 0, 0, 0);
    check("par_word0", 32'(w0), 32'h96);
    check("par_word1", 32'(w1), 32'h69);
    check("par_data", 32'(data_err), 32'd0);
    check("par_last", 32'(last_err), 32'd0);
    check("par_nwords", 32'(nwords), 32'd32);
    check("par_done_cyc", 32'(done_cyc), 32'd289);
    check("par_ndone", 32'(ndone), 32'd1);
    check("par_busy_after", 32'(busy_err), 32'd0);
    check("par_addr", 32'(addr_err), 32'd0);

    // MSB table
    mode = 1;
    sweep(-1, 0, 0, 0, 0);
    check("msb_word0", 32'(w0), 32'h00);
    check("msb_data", 32'(data_err), 32'd0);
    check("msb_nwords", 32'(nwords), 32'd32);
    check("msb_addr_seq", 32'(addr_err), 32'd0);
    check("msb_addr_end", 32'(lut_addr), 32'd0);

    // Backpressure on word 3, then random ready
    mode = 0;
    sweep(3, 20, 1, 0, 0);
    check("bp_stall_len", 32'(stall_seen), 32'd20);
    check("bp_stall_addr", 32'(stall_addr_err), 32'd0);
    check("bp_stable", 32'(stable_err), 32'd0);
    check("bp_data", 32'(data_err), 32'd0);
    check("bp_last", 32'(last_err), 32'd0);
    check("bp_nwords", 32'(nwords), 32'd32);
    check("bp_ndone", 32'(ndone), 32'd1);

    // Start pulses while busy are ignored
    sweep(-1, 0, 0, 1, 0);
    check("sb_nwords", 32'(nwords), 32'd32);
    check("sb_ndone", 32'(ndone), 32'd1);
    check("sb_data", 32'(data_err), 32'd0);
    check("sb_done_cyc", 32'(done_cyc), 32'd289);

    // Start held through the done cycle restarts immediately
    sweep(-1, 0, 0, 0, 1);
    check("hold_done", 32'(done), 32'd1);
    @(negedge clk);
    check("hold_busy_next", 32'(busy), 32'd1);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset during SEND of word 10
    start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 0; cyc = 0;
    while (cyc < 500) begin
      m_ready = 1'b1;
      if (m_valid && n == 10) begin rst = 1'b1; m_ready = 1'b0; break; end
      if (m_valid) n++;
      @(negedge clk);
      cyc++;
    end
    check("rs_reached", 32'(n), 32'd10);
    @(negedge clk);
    rst = 1'b0;
    check("rs_valid", 32'(m_valid), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_addr", 32'(lut_addr), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    dn = 0;
    repeat (5) begin @(negedge clk); if (done) dn = 1; end
    check("rs_no_done", 32'(dn), 32'd0);
    sweep(-1, 0, 0, 0, 0);
    check("rs_sweep_words", 32'(nwords), 32'd32);
    check("rs_sweep_data", 32'(data_err), 32'd0);
    check("rs_sweep_done", 32'(ndone), 32'd1);

    // Two-bit output instance
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; n = 0; err = 0; lerr = 0; cyc = 0; dn = 0;
    while (cyc < 1500 && !dn) begin
      if (valid2) begin
        if (mdata2 !== 8'hE4) err++;
        if (last2 !== (n == 63)) lerr++;
        n++;
      end
      if (done2) dn = 1;
      @(negedge clk);
      cyc++;
    end
    check("ob2_done", 32'(dn), 32'd1);
    check("ob2_nwords", 32'(n), 32'd64);
    check("ob2_data", 32'(err), 32'd0);
    check("ob2_last", 32'(lerr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
